// File: rtl/decoder_frame_assembler_pkg.sv
// Shared constants and types for the decoder frame assembler.
// Frame geometry follows the Viterbi traceback depth and the widest code rate.
package decoder_frame_assembler_pkg;

  localparam int unsigned TRACEBACK_DEPTH = 48;
  localparam int unsigned MAX_CODE_RATE   = 3;
  localparam int unsigned DEF_LEN_W       = 5;
  localparam int unsigned DEF_CNT_W       = 16;

  typedef enum logic {
    RATE_1_2 = 1'b0,
    RATE_1_3 = 1'b1
  } rate_e;

  localparam int unsigned N_R12 = TRACEBACK_DEPTH / 2;
  localparam int unsigned N_R13 = TRACEBACK_DEPTH / 3;

  function automatic int unsigned syms_per_frame(input rate_e rate, input int unsigned frame_w);
    return (rate == RATE_1_3) ? frame_w / 3 : frame_w / 2;
  endfunction

  function automatic int unsigned sym_bits(input rate_e rate);
    return (rate == RATE_1_3) ? 32'd3 : 32'd2;
  endfunction

endpackage

// File: rtl/decoder_frame_assembler_if.sv
// Symbol-in / frame-out bundle of the frame assembler.
// The slave modport is the assembler's view, master is the upstream/decoder side.
interface decoder_frame_assembler_if
  import decoder_frame_assembler_pkg::*;
#(
  parameter int unsigned SYM_W   = MAX_CODE_RATE,
  parameter int unsigned FRAME_W = TRACEBACK_DEPTH,
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned CNT_W   = DEF_CNT_W
);
  logic               i_rate_sel;
  logic [SYM_W-1:0]   i_sym;
  logic               i_sym_valid;
  logic               o_sym_ready;
  logic               i_flush;
  logic [FRAME_W-1:0] o_frame;
  logic [LEN_W-1:0]   o_frame_len;
  logic               o_frame_valid;
  logic               i_frame_ready;
  logic [CNT_W-1:0]   o_frame_cnt;

  modport master (
    output i_rate_sel, i_sym, i_sym_valid, i_flush, i_frame_ready,
    input  o_sym_ready, o_frame, o_frame_len, o_frame_valid, o_frame_cnt
  );

  modport slave (
    input  i_rate_sel, i_sym, i_sym_valid, i_flush, i_frame_ready,
    output o_sym_ready, o_frame, o_frame_len, o_frame_valid, o_frame_cnt
  );
endinterface

// File: rtl/decoder_frame_assembler_frame_out_reg.sv
// Valid/ready holding register for completed frames plus delivered-frame counter.
// o_free tells the packer it may load this edge (empty, or being drained now).
module decoder_frame_assembler_frame_out_reg #(
  parameter int unsigned FRAME_W = 48,
  parameter int unsigned LEN_W   = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [FRAME_W-1:0] i_frame,
  input  logic [LEN_W-1:0]   i_len,
  input  logic               i_ready,
  output logic               o_free,
  output logic [FRAME_W-1:0] o_frame,
  output logic [LEN_W-1:0]   o_len,
  output logic               o_valid,
  output logic [CNT_W-1:0]   o_cnt
);
  logic [FRAME_W-1:0] r_frame;
  logic [LEN_W-1:0]   r_len;
  logic               r_valid;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_take;

  assign w_take  = r_valid && i_ready;
  assign o_free  = !r_valid || i_ready;
  assign o_frame = r_frame;
  assign o_len   = r_len;
  assign o_valid = r_valid;
  assign o_cnt   = r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_frame <= '0;
      r_len   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_take) r_cnt <= r_cnt + CNT_W'(1);
      if (i_load) begin
        r_valid <= 1'b1;
        r_frame <= i_frame;
        r_len   <= i_len;
      end else if (w_take) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/decoder_frame_assembler.sv
// Packs 2- or 3-bit code symbols MSB-first into decoder frames, with flush of a
// zero-padded tail. The fill buffer parks a finished frame while the output is held.
module decoder_frame_assembler
  import decoder_frame_assembler_pkg::*;
#(
  parameter int unsigned SYM_W   = MAX_CODE_RATE,
  parameter int unsigned FRAME_W = TRACEBACK_DEPTH,
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input logic                      sys_clk,
  input logic                      rst,
  decoder_frame_assembler_if.slave bus
);
  logic [FRAME_W-1:0] r_fill;
  logic [LEN_W-1:0]   r_cnt;
  logic               r_full;
  rate_e              r_rate;

  rate_e              w_rate;
  int unsigned        w_sym_w;
  int unsigned        w_shift;
  logic [SYM_W-1:0]   w_mask;
  logic [FRAME_W-1:0] w_sym_ext;
  logic [FRAME_W-1:0] w_fill_next;
  logic [LEN_W-1:0]   w_cnt_new;
  logic [LEN_W-1:0]   w_n;
  logic               w_accept;
  logic               w_done;
  logic               w_free;
  logic               w_load;
  logic [FRAME_W-1:0] w_load_frame;
  logic [LEN_W-1:0]   w_load_len;

  assign w_accept        = bus.i_sym_valid && !r_full;
  assign bus.o_sym_ready = !r_full;

  // Rate comes straight from the input on the first symbol, from the latch after.
  always_comb begin
    w_rate      = (r_cnt == '0) ? rate_e'(bus.i_rate_sel) : r_rate;
    w_sym_w     = sym_bits(w_rate);
    w_n         = LEN_W'(syms_per_frame(w_rate, FRAME_W));
    w_mask      = SYM_W'((32'd1 << w_sym_w) - 32'd1);
    w_sym_ext   = FRAME_W'(bus.i_sym & w_mask);
    w_shift     = FRAME_W - (32'(r_cnt) + 32'd1) * w_sym_w;
    w_fill_next = w_accept ? (r_fill | (w_sym_ext << w_shift)) : r_fill;
    w_cnt_new   = r_cnt + LEN_W'(w_accept);
    w_done      = (w_accept && (w_cnt_new == w_n)) ||
                  (bus.i_flush && !r_full && (w_cnt_new != '0));
    w_load       = w_free && (r_full || w_done);
    w_load_frame = r_full ? r_fill : w_fill_next;
    w_load_len   = r_full ? r_cnt : w_cnt_new;
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      r_fill <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
      r_rate <= RATE_1_2;
    end else if (r_full) begin
      if (w_free) begin
        r_full <= 1'b0;
        r_fill <= '0;
        r_cnt  <= '0;
      end
    end else begin
      if (w_accept && (r_cnt == '0)) r_rate <= w_rate;
      if (w_done) begin
        if (w_free) begin
          r_fill <= '0;
          r_cnt  <= '0;
        end else begin
          r_fill <= w_fill_next;
          r_cnt  <= w_cnt_new;
          r_full <= 1'b1;
        end
      end else if (w_accept) begin
        r_fill <= w_fill_next;
        r_cnt  <= w_cnt_new;
      end
    end
  end

  decoder_frame_assembler_frame_out_reg #(
    .FRAME_W (FRAME_W),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) u_out (
    .i_clk   (sys_clk),
    .i_rst_n (rst),
    .i_load  (w_load),
    .i_frame (w_load_frame),
    .i_len   (w_load_len),
    .i_ready (bus.i_frame_ready),
    .o_free  (w_free),
    .o_frame (bus.o_frame),
    .o_len   (bus.o_frame_len),
    .o_valid (bus.o_frame_valid),
    .o_cnt   (bus.o_frame_cnt)
  );
endmodule

// File: tb/tb_decoder_frame_assembler.sv
// Scoreboard bench for decoder_frame_assembler: expected frames are queued as
// stimulus is driven and compared on every valid&ready handshake.
module tb_decoder_frame_assembler;
  import decoder_frame_assembler_pkg::*;

  logic sys_clk = 1'b0;
  logic rst     = 1'b0;
  always #5 sys_clk = ~sys_clk;

  decoder_frame_assembler_if bus ();

  decoder_frame_assembler dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [47:0] frame;
    logic [4:0]  len;
  } exp_t;

  exp_t        sb[$];
  logic [2:0]  syms_q[$];
  logic [15:0] exp_cnt = '0;
  int          checks   = 0;
  int          failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [47:0] model_pack(input bit r13);
    logic [47:0] f;
    int w;
    logic [2:0] s;
    f = '0;
    w = r13 ? 3 : 2;
    for (int k = 0; k < syms_q.size(); k++) begin
      s = syms_q[k];
      for (int j = 0; j < w; j++) f[47 - k*w - j] = s[w-1-j];
    end
    return f;
  endfunction

  task automatic push_exp(input logic [47:0] f, input logic [4:0] l);
    exp_t e;
    e.frame = f;
    e.len   = l;
    sb.push_back(e);
  endtask

  // Scoreboard side: compare on every handshake
  always @(negedge sys_clk) begin
    if (rst && bus.o_frame_valid && bus.i_frame_ready) begin
      if (sb.size() == 0) begin
        check_val("unexpected_frame", 64'(bus.o_frame), 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("frame", 64'(bus.o_frame), 64'(e.frame));
        check_val("frame_len", 64'(bus.o_frame_len), 64'(e.len));
      end
      check_val("frame_cnt", 64'(bus.o_frame_cnt), 64'(exp_cnt));
      exp_cnt = exp_cnt + 16'd1;
    end
  end

  task automatic send_sym(input logic [2:0] s, input logic rs);
    bus.i_sym       = s;
    bus.i_rate_sel  = rs;
    bus.i_sym_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge sys_clk);
      if (bus.o_sym_ready) begin
        @(posedge sys_clk);
        #1;
        bus.i_sym_valid = 1'b0;
        return;
      end
    end
    check_val("sym_timeout", 64'd0, 64'd1);
    bus.i_sym_valid = 1'b0;
  endtask

  task automatic send_random(input int n, input bit r13);
    logic [2:0] s;
    syms_q.delete();
    for (int i = 0; i < n; i++) begin
      s = 3'($urandom);
      syms_q.push_back(s);
      if (i == n - 1) push_exp(model_pack(r13), 5'(n));
      send_sym(s, r13);
    end
  endtask

  task automatic apply_reset_and_check(input string tag);
    rst = 1'b0;
    sb.delete();
    exp_cnt = '0;
    @(posedge sys_clk);
    #1;
    check_val({tag, "_valid"}, 64'(bus.o_frame_valid), 64'd0);
    check_val({tag, "_frame"}, 64'(bus.o_frame), 64'd0);
    check_val({tag, "_len"}, 64'(bus.o_frame_len), 64'd0);
    check_val({tag, "_cnt"}, 64'(bus.o_frame_cnt), 64'd0);
    check_val({tag, "_ready"}, 64'(bus.o_sym_ready), 64'd1);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_rate_sel    = 1'b0;
    bus.i_sym         = '0;
    bus.i_sym_valid   = 1'b0;
    bus.i_flush       = 1'b0;
    bus.i_frame_ready = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    apply_reset_and_check("rst_init");
    @(negedge sys_clk);
    check_val("ready_after_release", 64'(bus.o_sym_ready), 64'd1);
    @(posedge sys_clk);
    #1;

    // Rate 1/2 alternating pattern with latency and counter checks
    push_exp(48'h666666666666, 5'd24);
    for (int k = 0; k < 24; k++) send_sym((k % 2 == 0) ? 3'b001 : 3'b010, 1'b0);
    @(negedge sys_clk);
    check_val("r12_latency_valid", 64'(bus.o_frame_valid), 64'd1);
    check_val("r12_frame_direct", 64'(bus.o_frame), 64'h666666666666);
    @(posedge sys_clk);
    #1;
    check_val("r12_cnt_after", 64'(bus.o_frame_cnt), 64'd1);
    check_val("r12_valid_drop", 64'(bus.o_frame_valid), 64'd0);

    // Rate 1/3; rate select dropped mid-frame must not matter
    push_exp(48'hB6DB6DB6DB6D, 5'd16);
    for (int k = 0; k < 16; k++) send_sym(3'b101, (k < 4) ? 1'b1 : 1'b0);
    repeat (2) @(posedge sys_clk);
    #1;

    // Flush of a 5-symbol tail
    for (int k = 0; k < 5; k++) send_sym(3'b111, 1'b1);
    push_exp(48'hFFFE00000000, 5'd5);
    bus.i_flush = 1'b1;
    @(posedge sys_clk);
    #1;
    bus.i_flush = 1'b0;
    @(negedge sys_clk);
    check_val("flush_valid", 64'(bus.o_frame_valid), 64'd1);
    @(posedge sys_clk);
    #1;
    bus.i_flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      check_val("empty_flush_valid", 64'(bus.o_frame_valid), 64'd0);
    end
    @(posedge sys_clk);
    #1;
    bus.i_flush = 1'b0;

    // Backpressure: two frames, second parks in the fill buffer
    bus.i_frame_ready = 1'b0;
    push_exp(48'h666666666666, 5'd24);
    push_exp(48'h666666666666, 5'd24);
    for (int k = 0; k < 48; k++) send_sym((k % 2 == 0) ? 3'b001 : 3'b010, 1'b0);
    check_val("bp_ready_low", 64'(bus.o_sym_ready), 64'd0);
    bus.i_sym = 3'b011;
    bus.i_sym_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      check_val("bp_hold_frame", 64'(bus.o_frame), 64'h666666666666);
      check_val("bp_hold_len", 64'(bus.o_frame_len), 64'd24);
      check_val("bp_hold_valid", 64'(bus.o_frame_valid), 64'd1);
      check_val("bp_sym_blocked", 64'(bus.o_sym_ready), 64'd0);
    end
    @(posedge sys_clk);
    #1;
    bus.i_sym_valid = 1'b0;
    bus.i_frame_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    bus.i_frame_ready = 1'b0;
    @(negedge sys_clk);
    check_val("bp_second_valid", 64'(bus.o_frame_valid), 64'd1);
    check_val("bp_ready_back", 64'(bus.o_sym_ready), 64'd1);
    bus.i_frame_ready = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;

    // 24th symbol together with flush: one full frame only
    syms_q.delete();
    for (int k = 0; k < 24; k++) begin
      logic [2:0] s;
      s = 3'($urandom);
      syms_q.push_back(s);
      if (k == 23) begin
        push_exp(model_pack(1'b0), 5'd24);
        bus.i_flush = 1'b1;
      end
      send_sym(s, 1'b0);
    end
    bus.i_flush = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check_val("simul_sb_empty", 64'(sb.size()), 64'd0);

    // Reset mid-frame, then a clean frame
    for (int k = 0; k < 10; k++) send_sym(3'b111, 1'b0);
    apply_reset_and_check("rst_mid");
    send_random(24, 1'b0);
    repeat (2) @(posedge sys_clk);
    #1;

    // Reset while an output is held, then a clean rate 1/3 frame
    bus.i_frame_ready = 1'b0;
    send_random(24, 1'b0);
    for (int k = 0; k < 3; k++) send_sym(3'b111, 1'b0);
    check_val("held_before_rst", 64'(bus.o_frame_valid), 64'd1);
    apply_reset_and_check("rst_held");
    bus.i_frame_ready = 1'b1;
    send_random(16, 1'b1);
    repeat (3) @(posedge sys_clk);
    #1;
    check_val("final_sb_empty", 64'(sb.size()), 64'd0);
    check_val("final_cnt", 64'(bus.o_frame_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
